// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    typedef logic grant_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int STRB_W     = APB_DATA_W / 8;

    function automatic grant_t other(input grant_t g);
        return ~g;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB4 bus bundle between the arbiter (master) and one slave port.
interface apb_master_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin pick; the caller owns and updates last_grant.
module apb_rr_arbiter
    import apb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    input  logic       en,
    output logic       gnt_valid,
    output grant_t     gnt_idx
);

    always_comb begin
        gnt_valid = en && (req != 2'b00);
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = other(last_grant);
            default: gnt_idx = last_grant;
        endcase
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB4 master port between two requesters with round-robin grant,
// SETUP/ACCESS sequencing and a pready timeout. All outputs are registered.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                preset_n,

    input  logic                req_0,
    input  logic                req_write_0,
    input  logic [ADDR_W-1:0]   req_addr_0,
    input  logic [DATA_W-1:0]   req_wdata_0,
    input  logic [DATA_W/8-1:0] req_strb_0,
    output logic                ack_0,
    output logic [DATA_W-1:0]   rsp_rdata_0,
    output logic                rsp_err_0,

    input  logic                req_1,
    input  logic                req_write_1,
    input  logic [ADDR_W-1:0]   req_addr_1,
    input  logic [DATA_W-1:0]   req_wdata_1,
    input  logic [DATA_W/8-1:0] req_strb_1,
    output logic                ack_1,
    output logic [DATA_W-1:0]   rsp_rdata_1,
    output logic                rsp_err_1,

    apb_master_arbiter_if.master apb
);

    localparam int SW    = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e                   state_q, state_d;
    grant_t                   last_grant_q, last_grant_d;
    grant_t                   gidx_q, gidx_d;
    logic                     psel_q, psel_d;
    logic                     penable_q, penable_d;
    logic                     pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]        paddr_q, paddr_d;
    logic [DATA_W-1:0]        pwdata_q, pwdata_d;
    logic [SW-1:0]            pstrb_q, pstrb_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               ack_q, ack_d;
    logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]               err_q, err_d;

    logic                     gnt_valid;
    grant_t                   gnt_idx;
    logic [1:0]               req_elig;
    logic                     timeout_hit;

    logic                     sel_write;
    logic [ADDR_W-1:0]        sel_addr;
    logic [DATA_W-1:0]        sel_wdata;
    logic [SW-1:0]            sel_strb;

    // A requester still sees its own ack this cycle and has not yet dropped req.
    assign req_elig = {req_1, req_0} & ~ack_q;

    apb_rr_arbiter u_rr (
        .req        (req_elig),
        .last_grant (last_grant_q),
        .en         (state_q == IDLE),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    assign sel_write = gnt_idx ? req_write_1 : req_write_0;
    assign sel_addr  = gnt_idx ? req_addr_1  : req_addr_0;
    assign sel_wdata = gnt_idx ? req_wdata_1 : req_wdata_0;
    assign sel_strb  = gnt_idx ? req_strb_1  : req_strb_0;

    // cnt_q counts wait cycles already spent; this cycle is the TIMEOUT-th.
    assign timeout_hit = (TIMEOUT > 0) && !apb.pready && (cnt_q == TO_LAST);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (apb.pready || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        gidx_d       = gidx_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        cnt_d        = cnt_q;
        ack_d        = 2'b00;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            IDLE: if (gnt_valid) begin
                last_grant_d = gnt_idx;
                gidx_d       = gnt_idx;
                psel_d       = 1'b1;
                penable_d    = 1'b0;
                pwrite_d     = sel_write;
                paddr_d      = sel_addr;
                pwdata_d     = sel_write ? sel_wdata : '0;
                pstrb_d      = sel_write ? sel_strb  : '0;
                cnt_d        = '0;
            end
            SETUP: penable_d = 1'b1;
            ACCESS: begin
                if (apb.pready) begin
                    psel_d         = 1'b0;
                    penable_d      = 1'b0;
                    ack_d[gidx_q]  = 1'b1;
                    err_d[gidx_q]  = apb.pslverr;
                    if (!pwrite_q) rdata_d[gidx_q] = apb.prdata;
                end else if (timeout_hit) begin
                    psel_d          = 1'b0;
                    penable_d       = 1'b0;
                    ack_d[gidx_q]   = 1'b1;
                    err_d[gidx_q]   = 1'b1;
                    rdata_d[gidx_q] = '0;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            last_grant_q <= 1'b1;
            gidx_q       <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            cnt_q        <= '0;
            ack_q        <= 2'b00;
            rdata_q      <= '0;
            err_q        <= 2'b00;
        end else begin
            last_grant_q <= last_grant_d;
            gidx_q       <= gidx_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = pstrb_q;

    assign ack_0       = ack_q[0];
    assign ack_1       = ack_q[1];
    assign rsp_rdata_0 = rdata_q[0];
    assign rsp_rdata_1 = rdata_q[1];
    assign rsp_err_0   = err_q[0];
    assign rsp_err_1   = err_q[1];

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed table, hand sequences for contention
// and reset, and randomized alternating traffic against a memory model.
module tb_apb_master_arbiter;
    import apb_arb_pkg::*;

    localparam int TO = 16;

    logic pclk = 1'b0;
    logic preset_n;
    always #5 pclk = ~pclk;

    logic [1:0]  req, wr, ack, err;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  strb  [2];
    logic [31:0] rdata [2];

    apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) apb ();

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .req_0       (req[0]),
        .req_write_0 (wr[0]),
        .req_addr_0  (addr[0]),
        .req_wdata_0 (wdata[0]),
        .req_strb_0  (strb[0]),
        .ack_0       (ack[0]),
        .rsp_rdata_0 (rdata[0]),
        .rsp_err_0   (err[0]),
        .req_1       (req[1]),
        .req_write_1 (wr[1]),
        .req_addr_1  (addr[1]),
        .req_wdata_1 (wdata[1]),
        .req_strb_1  (strb[1]),
        .ack_1       (ack[1]),
        .rsp_rdata_1 (rdata[1]),
        .rsp_err_1   (err[1]),
        .apb         (apb.master)
    );

    // Slave: forced response for directed vectors, else a 16-word memory whose
    // wait states come from addr[3:2] and which errors on word 15.
    logic        slv_force, mem_init, f_err;
    int          f_wait;
    logic [31:0] f_rdata;
    logic [31:0] smem [16];
    int          acc_cnt = 0;
    int          cur_wait;
    logic [3:0]  sidx;

    always_comb begin
        sidx        = apb.paddr[5:2];
        cur_wait    = slv_force ? f_wait : int'(apb.paddr[3:2]);
        apb.pready  = apb.psel && apb.penable && (acc_cnt >= cur_wait);
        apb.prdata  = slv_force ? f_rdata : smem[sidx];
        apb.pslverr = slv_force ? f_err : (sidx == 4'hF);
    end

    always @(posedge pclk) begin
        if (apb.psel && apb.penable && !apb.pready) acc_cnt <= acc_cnt + 1;
        else                                        acc_cnt <= 0;
        if (mem_init) begin
            for (int i = 0; i < 16; i++) smem[i] <= 32'h1000_0000 + 32'(i);
        end else if (!slv_force && apb.pready && apb.pwrite && !apb.pslverr) begin
            for (int b = 0; b < 4; b++)
                if (apb.pstrb[b]) smem[sidx][8*b +: 8] <= apb.pwdata[8*b +: 8];
        end
    end

    logic [31:0] mdl_mem [16];
    logic [31:0] mdl_rd  [2];
    logic        mdl_er  [2];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        req      = 2'b00;
        repeat (2) @(posedge pclk);
        #1;
        preset_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            mdl_rd[r] = '0;
            mdl_er[r] = 1'b0;
        end
    endtask

    typedef struct {
        int          r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          nw;
        logic        se;
        logic [31:0] srd;
        logic [31:0] ed;
        logic        ee;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v);
        int lat;
        int o;
        lat = 0;
        o   = 1 - v.r;
        wr[v.r] = v.w; addr[v.r] = v.a; wdata[v.r] = v.d; strb[v.r] = v.s;
        req[v.r] = 1'b1;
        slv_force = 1'b1; f_wait = v.nw; f_rdata = v.srd; f_err = v.se;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            step();
            if (k == 1) chk("setup_phase", 64'({apb.psel, apb.penable}), 64'(2'b10));
            if (k == 2) chk("access_phase", 64'({apb.psel, apb.penable}), 64'(2'b11));
            if (apb.psel) begin
                chk("paddr",  64'(apb.paddr),  64'(v.a));
                chk("pwrite", 64'(apb.pwrite), 64'(v.w));
                chk("pstrb",  64'(apb.pstrb),  64'(v.w ? v.s : 4'h0));
                chk("pwdata", 64'(apb.pwdata), 64'(v.w ? v.d : 32'h0));
            end
            chk("other_ack", 64'(ack[o]), 64'(0));
            if (ack[v.r]) begin
                lat = k;
                chk("psel_drop", 64'({apb.psel, apb.penable}), 64'(0));
                chk("rsp_rdata", 64'(rdata[v.r]), 64'(v.ed));
                chk("rsp_err",   64'(err[v.r]),   64'(v.ee));
            end
        end
        chk("latency", 64'(lat), 64'(v.lat));
        req[v.r] = 1'b0;
        mdl_rd[v.r] = v.ed;
        mdl_er[v.r] = v.ee;
        chk("other_rdata_hold", 64'(rdata[o]), 64'(mdl_rd[o]));
        chk("other_err_hold",   64'(err[o]),   64'(mdl_er[o]));
        step();
    endtask

    task automatic contention();
        int order[$];
        int ackt[$];
        int got[2];
        got = '{0, 0};
        slv_force = 1'b1; f_wait = 0; f_rdata = 32'h77; f_err = 1'b0;
        wr = 2'b00; addr[0] = 32'h100; addr[1] = 32'h104;
        req = 2'b11;
        for (int k = 1; k <= 30 && order.size() < 4; k++) begin
            step();
            chk("ack_overlap", 64'(ack[0] && ack[1]), 64'(0));
            for (int r = 0; r < 2; r++) begin
                if (ack[r]) begin
                    order.push_back(r);
                    ackt.push_back(k);
                    chk("idle_gap_psel", 64'(apb.psel), 64'(0));
                    got[r]++;
                    if (got[r] == 2) req[r] = 1'b0;
                end
            end
        end
        chk("grant_count", 64'(order.size()), 64'(4));
        for (int i = 0; i < order.size(); i++) begin
            chk("grant_order", 64'(order[i]), 64'(i % 2));
            chk("ack_time",    64'(ackt[i]),  64'(3 * (i + 1)));
        end
        req = 2'b00;
        step();
    endtask

    task automatic reset_mid();
        int first;
        first = -1;
        slv_force = 1'b1; f_wait = 100; f_rdata = 32'h99; f_err = 1'b0;
        wr[0] = 1'b0; addr[0] = 32'h50; req[0] = 1'b1;
        repeat (3) step();
        chk("in_access", 64'({apb.psel, apb.penable}), 64'(2'b11));
        #2 preset_n = 1'b0;
        #1;
        chk("rst_async_bus", 64'({apb.psel, apb.penable, ack}), 64'(0));
        chk("rst_async_rsp", 64'({err, rdata[0]}), 64'(0));
        req = 2'b00;
        step();
        preset_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            mdl_rd[r] = '0;
            mdl_er[r] = 1'b0;
        end
        f_wait = 0;
        wr = 2'b00; addr[0] = 32'h60; addr[1] = 32'h64;
        req = 2'b11;
        for (int k = 1; k <= 20 && first < 0; k++) begin
            step();
            if (ack[0])      first = 0;
            else if (ack[1]) first = 1;
        end
        chk("post_rst_winner", 64'(first), 64'(0));
        // requester 1 withdraws before being granted: it must not be served
        req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("dropped_not_served", 64'({apb.psel, ack}), 64'(0));
        end
    endtask

    task automatic gen(input int r);
        wr[r]    = 1'($urandom_range(0, 1));
        addr[r]  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        wdata[r] = $urandom;
        strb[r]  = 4'($urandom_range(0, 15));
    endtask

    task automatic rand_test(input int n);
        int left[2];
        int turn, last, done, cyc;
        turn = 0; last = 0; done = 0; cyc = 0;
        do_reset();
        slv_force = 1'b0;
        mem_init  = 1'b1;
        step();
        mem_init  = 1'b0;
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'h1000_0000 + 32'(i);
        left = '{n, n};
        gen(0); gen(1);
        req = 2'b11;
        while (done < 2 * n && cyc < 2000) begin
            step();
            cyc++;
            chk("rnd_ack_overlap", 64'(ack[0] && ack[1]), 64'(0));
            for (int r = 0; r < 2; r++) begin
                if (ack[r]) begin
                    logic [3:0] idx;
                    logic       e;
                    idx = addr[r][5:2];
                    e   = (idx == 4'hF);
                    chk("rnd_order", 64'(r), 64'(turn));
                    turn = 1 - r;
                    chk("rnd_latency", 64'(cyc - last), 64'(3 + int'(addr[r][3:2])));
                    if (!wr[r]) mdl_rd[r] = mdl_mem[idx];
                    mdl_er[r] = e;
                    chk("rnd_rdata", 64'(rdata[r]), 64'(mdl_rd[r]));
                    chk("rnd_err",   64'(err[r]),   64'(mdl_er[r]));
                    if (wr[r] && !e)
                        for (int b = 0; b < 4; b++)
                            if (strb[r][b]) mdl_mem[idx][8*b +: 8] = wdata[r][8*b +: 8];
                    last = cyc;
                    done++;
                    left[r]--;
                    if (left[r] > 0) gen(r);
                    else             req[r] = 1'b0;
                end
            end
        end
        chk("rnd_done", 64'(done), 64'(2 * n));
        req = 2'b00;
        step();
    endtask

    initial begin
        //            r  w     addr          wdata          strb nw   se    srd            exp_rdata      ee   lat
        vecs[0] = '{0, 1'b1, 32'h0000_000C, 32'h0000_00A5, 4'hF, 0,   1'b0, 32'h0000_0BAD, 32'h0,         1'b0, 3};
        vecs[1] = '{1, 1'b0, 32'h0000_0014, 32'h0,         4'hF, 2,   1'b0, 32'h0000_0060, 32'h0000_0060, 1'b0, 5};
        vecs[2] = '{0, 1'b1, 32'h0000_0FFC, 32'h0000_0011, 4'hF, 0,   1'b1, 32'h0000_0BAD, 32'h0,         1'b1, 3};
        vecs[3] = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 1,   1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4};
        vecs[4] = '{1, 1'b1, 32'h0000_0030, 32'h0000_1234, 4'h3, 0,   1'b0, 32'h0000_0BAD, 32'h0000_0060, 1'b0, 3};
        vecs[5] = '{1, 1'b0, 32'h0000_0040, 32'h0,         4'hF, 0,   1'b1, 32'h0000_CAFE, 32'h0000_CAFE, 1'b1, 3};
        vecs[6] = '{0, 1'b0, 32'h0000_0044, 32'h0,         4'h0, 100, 1'b0, 32'h0000_5555, 32'h0,         1'b1, 18};
        vecs[7] = '{1, 1'b0, 32'h0000_0048, 32'h0,         4'h0, 15,  1'b0, 32'h0000_0077, 32'h0000_0077, 1'b0, 18};
        vecs[8] = '{0, 1'b1, 32'h0000_0008, 32'hFFFF_0000, 4'hC, 0,   1'b0, 32'h0000_0BAD, 32'h0,         1'b0, 3};

        preset_n  = 1'b0;
        req       = 2'b00;
        wr        = 2'b00;
        slv_force = 1'b1;
        mem_init  = 1'b0;
        f_wait    = 0;
        f_rdata   = '0;
        f_err     = 1'b0;
        for (int r = 0; r < 2; r++) begin
            addr[r] = '0; wdata[r] = '0; strb[r] = '0;
            mdl_rd[r] = '0; mdl_er[r] = 1'b0;
        end
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_ctrl",  64'({apb.psel, apb.penable, apb.pwrite}), 64'(0));
        chk("rst_paddr", 64'(apb.paddr), 64'(0));
        chk("rst_wdata", 64'({apb.pwdata, apb.pstrb}), 64'(0));
        chk("rst_ack",   64'(ack), 64'(0));
        chk("rst_rsp",   64'({rdata[0], rdata[1]}), 64'(0));
        chk("rst_err",   64'(err), 64'(0));
        preset_n = 1'b1;
        step();
        chk("idle_no_req", 64'(apb.psel), 64'(0));

        contention();
        do_reset();
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);
        reset_mid();
        rand_test(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

endmodule
